// File: rtl/pdm_sample_feeder.sv
// Sample feeder for the PDM DAC: buffers signed samples in a small FIFO and
// releases one per prescaler period, volume-scaled and converted to offset-binary.
module pdm_sample_feeder #(
    parameter int DATA_BITS  = 12,
    parameter int VOL_BITS   = 8,
    parameter int CLK_DIV    = 1000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic [VOL_BITS-1:0]           volume,
    output logic [DATA_BITS-1:0]          dout,
    output logic                          sample_tick,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = DATA_BITS + VOL_BITS + 1;

    localparam logic [CW-1:0]        CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [LW-1:0]        LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [DATA_BITS-1:0] MIDSCALE = {1'b1, {(DATA_BITS-1){1'b0}}};

    // Signed sample times unsigned volume, floor-shifted back to sample width,
    // then MSB flipped to offset-binary. The product cannot overflow PW bits.
    function automatic logic [DATA_BITS-1:0] scale_to_offset(
        input logic [DATA_BITS-1:0] smp,
        input logic [VOL_BITS-1:0]  vol
    );
        logic signed [PW-1:0]        smp_ext;
        logic signed [PW-1:0]        vol_ext;
        logic signed [PW-1:0]        prod;
        logic        [DATA_BITS-1:0] scaled;
        smp_ext = $signed({{(VOL_BITS+1){smp[DATA_BITS-1]}}, smp});
        vol_ext = $signed({{(DATA_BITS+1){1'b0}}, vol});
        prod    = smp_ext * vol_ext;
        scaled  = DATA_BITS'(prod >>> VOL_BITS);
        return {~scaled[DATA_BITS-1], scaled[DATA_BITS-2:0]};
    endfunction

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [LW-1:0]        level_r;
    logic [CW-1:0]        cnt_r;
    logic [DATA_BITS-1:0] dout_r;
    logic                 tick_r;
    logic                 underrun_r;

    logic                 term_s;
    logic                 empty_s;
    logic                 push_s;
    logic                 pop_s;

    assign sample_ready = (level_r != LVL_FULL);
    assign fifo_level   = level_r;
    assign dout         = dout_r;
    assign sample_tick  = tick_r;
    assign underrun     = underrun_r;

    // Handshake and tick qualifiers; a pop only happens when the FIFO held data
    // before this edge, so a push into an empty FIFO on a tick still underruns.
    always_comb begin
        term_s  = (cnt_r == CNT_LAST);
        empty_s = (level_r == {LW{1'b0}});
        push_s  = sample_valid && sample_ready;
        pop_s   = term_s && !empty_s;
    end

    // Sample-rate prescaler: counts 0..CLK_DIV-1 and wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (term_s) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= sample_in;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Output register and the one-cycle tick/underrun pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r     <= MIDSCALE;
            tick_r     <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            tick_r     <= term_s;
            underrun_r <= term_s && empty_s;
            if (pop_s) begin
                dout_r <= scale_to_offset(mem_r[rd_ptr_r], volume);
            end
        end
    end

endmodule

// File: tb/tb_pdm_sample_feeder.sv
// Directed self-checking bench for pdm_sample_feeder with a short prescaler
// (CLK_DIV=8): reset, scaling cases, full FIFO, tick-time push and mid-run reset.
module tb_pdm_sample_feeder;

    localparam int DATA_BITS  = 12;
    localparam int VOL_BITS   = 8;
    localparam int CLK_DIV    = 8;
    localparam int FIFO_DEPTH = 4;

    logic                 clk;
    logic                 rst;
    logic [DATA_BITS-1:0] sample_in;
    logic                 sample_valid;
    logic                 sample_ready;
    logic [VOL_BITS-1:0]  volume;
    logic [DATA_BITS-1:0] dout;
    logic                 sample_tick;
    logic                 underrun;
    logic [2:0]           fifo_level;

    int n_checks;
    int n_pass;
    int cyc_no;

    pdm_sample_feeder #(
        .DATA_BITS (DATA_BITS),
        .VOL_BITS  (VOL_BITS),
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .volume      (volume),
        .dout        (dout),
        .sample_tick (sample_tick),
        .underrun    (underrun),
        .fifo_level  (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_no);
        end
    endtask

    // Advance n cycles; always resumes on a falling edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            cyc_no++;
        end
    endtask

    // Advance to the next cycle in which the tick pulse is expected.
    task automatic to_pulse();
        do cyc(1); while (cyc_no % CLK_DIV != 0);
    endtask

    task automatic push_and_tick(input string tag, input logic [11:0] smp,
                                 input logic [7:0] vol, input logic [11:0] exp);
        volume       = vol;
        sample_in    = smp;
        sample_valid = 1'b1;
        cyc(1);
        sample_valid = 1'b0;
        check_eq({tag, "_lvl1"}, 32'(fifo_level), 32'd1);
        to_pulse();
        check_eq({tag, "_dout"}, 32'(dout), 32'(exp));
        check_eq({tag, "_tick"}, 32'(sample_tick), 32'd1);
        check_eq({tag, "_urun"}, 32'(underrun), 32'd0);
        check_eq({tag, "_lvl0"}, 32'(fifo_level), 32'd0);
    endtask

    logic [11:0] fill_smp [5];
    logic [11:0] fill_exp [5];

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        cyc_no       = 0;
        rst          = 1'b1;
        sample_in    = 12'h000;
        sample_valid = 1'b0;
        volume       = 8'd0;
        fill_smp = '{12'h100, 12'h200, 12'hF00, 12'h002, 12'h7FE};
        fill_exp = '{12'h880, 12'h900, 12'h780, 12'h801, 12'hBFF};

        @(negedge clk);
        cyc(2);
        check_eq("rst_dout",  32'(dout), 32'h800);
        check_eq("rst_ready", 32'(sample_ready), 32'd1);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        check_eq("rst_tick",  32'(sample_tick), 32'd0);
        check_eq("rst_urun",  32'(underrun), 32'd0);

        // Empty run: pulses in cycles 8 and 16 only.
        rst    = 1'b0;
        cyc_no = 0;
        cyc(7);
        check_eq("c7_tick", 32'(sample_tick), 32'd0);
        cyc(1);
        check_eq("c8_tick", 32'(sample_tick), 32'd1);
        check_eq("c8_urun", 32'(underrun), 32'd1);
        check_eq("c8_dout", 32'(dout), 32'h800);
        cyc(1);
        check_eq("c9_tick", 32'(sample_tick), 32'd0);
        check_eq("c9_urun", 32'(underrun), 32'd0);
        cyc(7);
        check_eq("c16_tick", 32'(sample_tick), 32'd1);
        check_eq("c16_urun", 32'(underrun), 32'd1);

        // Scaling cases.
        push_and_tick("max",   12'h7FF, 8'd255, 12'hFF7);
        push_and_tick("neg",   12'h800, 8'd128, 12'h400);
        push_and_tick("vol0",  12'h123, 8'd0,   12'h800);
        push_and_tick("floor", 12'hFFF, 8'd1,   12'h7FF);

        // Full FIFO: four accepted, fifth held until a tick frees a slot.
        volume       = 8'd128;
        sample_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample_in = fill_smp[i];
            cyc(1);
        end
        sample_in = fill_smp[4];
        check_eq("full_level", 32'(fifo_level), 32'd4);
        check_eq("full_ready", 32'(sample_ready), 32'd0);
        cyc(3);
        check_eq("full_hold_level", 32'(fifo_level), 32'd4);
        check_eq("full_hold_ready", 32'(sample_ready), 32'd0);
        cyc(1);
        check_eq("pop_level", 32'(fifo_level), 32'd3);
        check_eq("pop_ready", 32'(sample_ready), 32'd1);
        check_eq("pop_tick",  32'(sample_tick), 32'd1);
        check_eq("order_0",   32'(dout), 32'(fill_exp[0]));
        cyc(1);
        sample_valid = 1'b0;
        check_eq("refill_level", 32'(fifo_level), 32'd4);
        for (int i = 1; i < 5; i++) begin
            to_pulse();
            check_eq($sformatf("order_%0d", i), 32'(dout), 32'(fill_exp[i]));
            check_eq($sformatf("order_urun_%0d", i), 32'(underrun), 32'd0);
        end
        check_eq("drained", 32'(fifo_level), 32'd0);

        // Push in the terminal cycle while empty.
        cyc(CLK_DIV - 1);
        sample_in    = 12'h400;
        sample_valid = 1'b1;
        cyc(1);
        sample_valid = 1'b0;
        check_eq("term_push_urun",  32'(underrun), 32'd1);
        check_eq("term_push_tick",  32'(sample_tick), 32'd1);
        check_eq("term_push_dout",  32'(dout), 32'hBFF);
        check_eq("term_push_level", 32'(fifo_level), 32'd1);
        to_pulse();
        check_eq("term_next_dout", 32'(dout), 32'hA00);
        check_eq("term_next_urun", 32'(underrun), 32'd0);
        check_eq("term_next_tick", 32'(sample_tick), 32'd1);

        // Mid-run reset flushes the FIFO and restarts the prescaler.
        sample_valid = 1'b1;
        sample_in    = 12'h010;
        cyc(1);
        sample_in    = 12'h020;
        cyc(1);
        sample_in    = 12'h030;
        cyc(1);
        sample_valid = 1'b0;
        check_eq("pre_rst_level3", 32'(fifo_level), 32'd3);
        to_pulse();
        check_eq("pre_rst_dout",  32'(dout), 32'h808);
        check_eq("pre_rst_level", 32'(fifo_level), 32'd2);
        rst = 1'b1;
        cyc(1);
        rst    = 1'b0;
        cyc_no = 0;
        check_eq("mid_rst_dout",  32'(dout), 32'h800);
        check_eq("mid_rst_level", 32'(fifo_level), 32'd0);
        check_eq("mid_rst_ready", 32'(sample_ready), 32'd1);
        check_eq("mid_rst_tick",  32'(sample_tick), 32'd0);
        cyc(7);
        check_eq("post_rst_c7_tick", 32'(sample_tick), 32'd0);
        cyc(1);
        check_eq("post_rst_c8_tick", 32'(sample_tick), 32'd1);
        check_eq("post_rst_c8_urun", 32'(underrun), 32'd1);
        check_eq("post_rst_c8_dout", 32'(dout), 32'h800);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
